// File: rtl/bitwise_op_ctrl_pkg.sv
// Shared definitions for the bitwise-unit sequencer.
//   - Opcode encodings seen on the request ports (3 bits).
//   - Function selects driven to the shared combinational bitwise unit (2 bits).
//   - Controller state encoding (2 bits).
package bitwise_op_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_XOR = 2'b10;
  localparam logic [1:0] FN_NOT = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC1 = 2'd1;
  localparam logic [1:0] ST_EXEC2 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Opcodes with the top bit set need a second pass through the unit.
  function automatic logic is_compound(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/bitwise_op_ctrl_if.sv
// Bundle of the request, response and bitwise-unit signals of the sequencer.
//   master : requesters / result consumer / bitwise unit side
//   slave  : the bitwise_op_ctrl controller
interface bitwise_op_ctrl_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic [15:0] bw_a;
  logic [15:0] bw_b;
  logic [1:0]  bw_funct;
  logic [15:0] bw_out;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, bw_out,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero,
    input  bw_a, bw_b, bw_funct
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, bw_out,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero,
    output bw_a, bw_b, bw_funct
  );
endinterface

// File: rtl/bitwise_rr_arb2.sv
// Two-requester grant logic.
//   clk, rst : clock, synchronous active-high reset
//   en       : grants allowed this cycle (controller idle and not in reset)
//   valid    : per-port request valid
//   grant    : one-hot (or zero) grant; a grant is also the handshake
// RR_EN=1 alternates on ties using last_grant; RR_EN=0 always prefers port 0.
module bitwise_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic       last_grant_reg;
  logic       last_grant_next;
  logic [1:0] prefer;

  // On a tie the port that did not win last time is preferred.
  assign prefer[0] = RR_EN ? last_grant_reg : 1'b1;
  assign prefer[1] = RR_EN ? ~last_grant_reg : 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign grant[gi] = en & valid[gi] & (~valid[1-gi] | prefer[gi]);
    end
  endgenerate

  // Only an actual handshake moves the round-robin pointer.
  assign last_grant_next = (|grant) ? grant[1] : last_grant_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: rtl/bitwise_op_ctrl.sv
// Sequencer and two-port arbiter for a shared 16-bit combinational bitwise unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request ports 0/1, response port, bitwise unit drive/return
//   busy     : controller not idle
//   op_count : completed responses, wrapping 16-bit counter
// Compound ops (NAND/NOR/XNOR/ANDN) take two passes; the first pass result is
// kept in tmp and fed back on the second pass.
module bitwise_op_ctrl
  import bitwise_op_ctrl_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  bitwise_op_ctrl_if.slave   bus,
  output logic               busy,
  output logic [15:0]        op_count
);

  logic [1:0]  state_reg, state_next;
  logic [2:0]  op_reg, op_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] b_reg, b_next;
  logic        id_reg, id_next;
  logic [15:0] tmp_reg, tmp_next;
  logic [15:0] data_reg, data_next;
  logic        zero_reg, zero_next;
  logic [15:0] op_count_reg, op_count_next;
  logic [1:0]  grant;
  logic        arb_en;

  // Ready is suppressed during reset so nothing is accepted in that cycle.
  assign arb_en = (state_reg == ST_IDLE) & ~rst;

  bitwise_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp_valid  = (state_reg == ST_DONE);
  assign bus.rsp_data   = data_reg;
  assign bus.rsp_id     = id_reg;
  assign bus.rsp_zero   = zero_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign op_count       = op_count_reg;

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    id_next       = id_reg;
    tmp_next      = tmp_reg;
    data_next     = data_reg;
    zero_next     = zero_reg;
    op_count_next = op_count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|grant) begin
          id_next    = grant[1];
          op_next    = grant[1] ? bus.req1_op : bus.req0_op;
          a_next     = grant[1] ? bus.req1_a  : bus.req0_a;
          b_next     = grant[1] ? bus.req1_b  : bus.req0_b;
          state_next = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        tmp_next = bus.bw_out;
        if (is_compound(op_reg)) begin
          state_next = ST_EXEC2;
        end else begin
          data_next  = bus.bw_out;
          zero_next  = (bus.bw_out == 16'h0000);
          state_next = ST_DONE;
        end
      end
      ST_EXEC2: begin
        data_next  = bus.bw_out;
        zero_next  = (bus.bw_out == 16'h0000);
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          op_count_next = op_count_reg + 16'd1;
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Unit drive. Pass 1 of every compound op reuses the single-pass function
  // in op[1:0]; ANDN inverts b first, so its pass 1 presents b on bw_a.
  always_comb begin
    bus.bw_a     = 16'h0000;
    bus.bw_b     = 16'h0000;
    bus.bw_funct = FN_AND;
    case (state_reg)
      ST_EXEC1: begin
        bus.bw_a = (op_reg == OP_ANDN) ? b_reg : a_reg;
        bus.bw_b = b_reg;
        case (op_reg)
          OP_AND, OP_NAND: bus.bw_funct = FN_AND;
          OP_OR,  OP_NOR:  bus.bw_funct = FN_OR;
          OP_XOR, OP_XNOR: bus.bw_funct = FN_XOR;
          OP_NOT, OP_ANDN: bus.bw_funct = FN_NOT;
          default:         bus.bw_funct = FN_NOT;
        endcase
      end
      ST_EXEC2: begin
        if (op_reg == OP_ANDN) begin
          bus.bw_a     = a_reg;
          bus.bw_b     = tmp_reg;
          bus.bw_funct = FN_AND;
        end else begin
          bus.bw_a     = tmp_reg;
          bus.bw_funct = FN_NOT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_AND;
      a_reg        <= 16'h0000;
      b_reg        <= 16'h0000;
      id_reg       <= 1'b0;
      tmp_reg      <= 16'h0000;
      data_reg     <= 16'h0000;
      zero_reg     <= 1'b0;
      op_count_reg <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      id_reg       <= id_next;
      tmp_reg      <= tmp_next;
      data_reg     <= data_next;
      zero_reg     <= zero_next;
      op_count_reg <= op_count_next;
    end
  end

endmodule

// File: tb/tb_bitwise_op_ctrl.sv
// Self-checking bench for bitwise_op_ctrl: a round-robin instance carries most
// scenarios, a fixed-priority instance covers RR_EN=0. Expected responses are
// queued at each handshake and compared while the DUT presents them.
module tb_bitwise_op_ctrl;
  import bitwise_op_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitwise_op_ctrl_if bus();
  bitwise_op_ctrl_if fp_bus();
  logic        busy, fp_busy;
  logic [15:0] op_count, fp_op_count;

  bitwise_op_ctrl #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .op_count(op_count)
  );
  bitwise_op_ctrl #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .bus(fp_bus), .busy(fp_busy), .op_count(fp_op_count)
  );

  typedef struct { logic id; logic [15:0] data; } exp_t;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  int          cyc = 0;
  int          valid_start_cyc = -1;
  logic        prev_valid = 1'b0;
  logic [15:0] exp_count = 16'h0000;

  function automatic logic [15:0] bw_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] f);
    case (f)
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a & ~b;
    endcase
  endfunction

  // Combinational bitwise unit shared by each controller instance.
  assign bus.bw_out    = bw_fn(bus.bw_a, bus.bw_b, bus.bw_funct);
  assign fp_bus.bw_out = bw_fn(fp_bus.bw_a, fp_bus.bw_b, fp_bus.bw_funct);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: every cycle a response is shown it must match the head
  // of the scoreboard; it is retired when rsp_ready is also high.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.rsp_valid) begin
      if (!prev_valid) valid_start_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, expected no response",
                 bus.rsp_id, bus.rsp_data);
      end else if (bus.rsp_data !== sb[0].data || bus.rsp_id !== sb[0].id ||
                   bus.rsp_zero !== (sb[0].data == 16'h0000)) begin
        n_fail++;
        $display("FAIL rsp_match: got id=%0d data=%h zero=%0d, expected id=%0d data=%h zero=%0d",
                 bus.rsp_id, bus.rsp_data, bus.rsp_zero, sb[0].id, sb[0].data,
                 (sb[0].data == 16'h0000));
      end
      if (bus.rsp_ready) begin
        $display("rsp  id=%0d data=%h cycle=%0d", bus.rsp_id, bus.rsp_data, cyc);
        if (sb.size() > 0) void'(sb.pop_front());
        n_pops++;
        exp_count++;
      end
    end
    prev_valid = rst ? 1'b0 : bus.rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int port, input logic v, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Present one request and hold it until accepted; returns the handshake
  // cycle and leaves the caller at the start of the following cycle.
  task automatic issue(input int port, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int hs);
    exp_t e;
    hs = -1;
    drive_port(port, 1'b1, op, a, b);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rdy(port)) begin
        hs = cyc;
        e.id = port[0];
        e.data = ref_op(op, a, b);
        sb.push_back(e);
        $display("req  port=%0d op=%0d a=%h b=%h cycle=%0d", port, op, a, b, hs);
        tick();
        break;
      end
      tick();
    end
    drive_port(port, 1'b0, op, a, b);
    if (hs < 0) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: port %0d never ready, required a handshake", port);
    end
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 30 && n_pops < target; i++) tick();
    n_checks++;
    if (n_pops < target) begin
      n_fail++;
      $display("FAIL rsp_timeout: got %0d responses, required %0d", n_pops, target);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    exp_count = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_port(0, 1'b1, OP_AND, 16'h1111, 16'h2222);
    drive_port(1, 1'b1, OP_OR, 16'h3333, 16'h4444);
    tick(); tick(); tick();
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 00", {bus.req0_ready, bus.req1_ready});
    end
    n_checks++;
    if ({bus.rsp_valid, busy, bus.rsp_id, bus.rsp_zero} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/id/zero=%b, required 0000",
               {bus.rsp_valid, busy, bus.rsp_id, bus.rsp_zero});
    end
    n_checks++;
    if (bus.rsp_data !== 16'h0000 || op_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_regs: got data=%h count=%h, required 0000/0000",
               bus.rsp_data, op_count);
    end
    n_checks++;
    if (bus.bw_a !== 16'h0 || bus.bw_b !== 16'h0 || bus.bw_funct !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_bw: got a=%h b=%h f=%b, required zeros",
               bus.bw_a, bus.bw_b, bus.bw_funct);
    end
    drive_port(0, 1'b0, OP_AND, 16'h0, 16'h0);
    drive_port(1, 1'b0, OP_AND, 16'h0, 16'h0);
    rst = 1'b0;
    sb.delete();
    exp_count = 16'h0000;
    tick();
  endtask

  task automatic test_xor();
    int hs;
    int target;
    bus.rsp_ready = 1'b1;
    target = n_pops + 1;
    issue(0, OP_XOR, 16'h1234, 16'h00FF, hs);
    n_checks++;
    if (bus.bw_funct !== FN_XOR || bus.bw_a !== 16'h1234 || bus.bw_b !== 16'h00FF) begin
      n_fail++;
      $display("FAIL xor_pass1: got f=%b a=%h b=%h, required 10/1234/00ff",
               bus.bw_funct, bus.bw_a, bus.bw_b);
    end
    wait_rsp(target);
    n_checks++;
    if (valid_start_cyc != hs + 2) begin
      n_fail++;
      $display("FAIL xor_latency: got cycle %0d, required %0d", valid_start_cyc, hs + 2);
    end
    n_checks++;
    if (op_count !== 16'd1) begin
      n_fail++;
      $display("FAIL xor_count: got %h, required 0001", op_count);
    end
  endtask

  task automatic test_compound();
    int hs;
    int target;
    logic [2:0]  op;
    logic [15:0] a, b;
    target = n_pops + 1;
    issue(0, OP_NAND, 16'hF0F0, 16'hFF00, hs);
    n_checks++;
    if (bus.bw_funct !== FN_AND || bus.bw_a !== 16'hF0F0) begin
      n_fail++;
      $display("FAIL nand_pass1: got f=%b a=%h, required 00/f0f0", bus.bw_funct, bus.bw_a);
    end
    tick();
    n_checks++;
    if (bus.bw_funct !== FN_NOT || bus.bw_a !== 16'hF000) begin
      n_fail++;
      $display("FAIL nand_pass2: got f=%b a=%h, required 11/f000", bus.bw_funct, bus.bw_a);
    end
    wait_rsp(target);
    n_checks++;
    if (valid_start_cyc != hs + 3) begin
      n_fail++;
      $display("FAIL nand_latency: got cycle %0d, required %0d", valid_start_cyc, hs + 3);
    end
    target = n_pops + 1;
    issue(1, OP_ANDN, 16'hFFFF, 16'h00FF, hs);
    n_checks++;
    if (bus.bw_funct !== FN_NOT || bus.bw_a !== 16'h00FF) begin
      n_fail++;
      $display("FAIL andn_pass1: got f=%b a=%h, required 11/00ff", bus.bw_funct, bus.bw_a);
    end
    tick();
    n_checks++;
    if (bus.bw_funct !== FN_AND || bus.bw_a !== 16'hFFFF || bus.bw_b !== 16'hFF00) begin
      n_fail++;
      $display("FAIL andn_pass2: got f=%b a=%h b=%h, required 00/ffff/ff00",
               bus.bw_funct, bus.bw_a, bus.bw_b);
    end
    wait_rsp(target);
    for (int k = 0; k < 8; k++) begin
      op = k[2:0];
      a = 16'($urandom);
      b = 16'($urandom);
      target = n_pops + 1;
      issue(k % 2, op, a, b, hs);
      wait_rsp(target);
      n_checks++;
      if (valid_start_cyc != hs + (op[2] ? 3 : 2)) begin
        n_fail++;
        $display("FAIL op%0d_latency: got cycle %0d, required %0d", k, valid_start_cyc,
                 hs + (op[2] ? 3 : 2));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] a0, a1;
    exp_t e;
    int g;
    int target;
    apply_reset();
    target = n_pops + 4;
    a0 = 16'h1111;
    a1 = 16'h2222;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = -1;
      drive_port(0, 1'b1, OP_AND, a0, 16'h0F0F);
      drive_port(1, 1'b1, OP_AND, a1, 16'h0F0F);
      for (int i = 0; i < 10 && g < 0; i++) begin
        #1;
        if (bus.req0_ready || bus.req1_ready) begin
          g = bus.req1_ready ? 1 : 0;
          e.id = g[0];
          e.data = ref_op(OP_AND, g ? a1 : a0, 16'h0F0F);
          sb.push_back(e);
          $display("req  port=%0d op=0 a=%h b=0f0f cycle=%0d", g, g ? a1 : a0, cyc);
        end
        tick();
      end
      n_checks++;
      if (g != k % 2) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got port %0d, required %0d", k, g, k % 2);
      end
      if (g == 0) a0 = a0 + 16'h0101;
      if (g == 1) a1 = a1 + 16'h0101;
    end
    drive_port(0, 1'b0, OP_AND, a0, 16'h0);
    drive_port(1, 1'b0, OP_AND, a1, 16'h0);
    wait_rsp(target);
  endtask

  task automatic test_fixed_priority();
    int g;
    for (int k = 0; k < 4; k++) begin
      g = -1;
      fp_bus.req0_valid = (k < 3);
      fp_bus.req1_valid = 1'b1;
      for (int i = 0; i < 10 && g < 0; i++) begin
        #1;
        if (fp_bus.req0_ready || fp_bus.req1_ready) g = fp_bus.req1_ready ? 1 : 0;
        tick();
      end
      n_checks++;
      if (g != ((k < 3) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL fp_grant%0d: got port %0d, required %0d", k, g, (k < 3) ? 0 : 1);
      end
    end
    fp_bus.req0_valid = 1'b0;
    fp_bus.req1_valid = 1'b0;
    for (int i = 0; i < 20 && fp_op_count != 16'd4; i++) tick();
    n_checks++;
    if (fp_op_count !== 16'd4 || fp_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_count: got count=%h busy=%0d, required 0004/0", fp_op_count, fp_busy);
    end
  endtask

  task automatic test_backpressure();
    int hs;
    int target;
    bus.rsp_ready = 1'b0;
    target = n_pops + 1;
    issue(0, OP_OR, 16'hA5A0, 16'h0005, hs);
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) tick();
    for (int s = 0; s < 5; s++) begin
      drive_port(1, 1'b1, OP_XOR, 16'h5555, 16'h00FF);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hA5A5 || bus.rsp_id !== 1'b0 ||
          busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          op_count !== exp_count) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%0d d=%h id=%0d busy=%0d rdy=%b cnt=%h, required 1/a5a5/0/1/00/%h",
                 s, bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy,
                 {bus.req0_ready, bus.req1_ready}, op_count, exp_count);
      end
      tick();
    end
    drive_port(1, 1'b0, OP_XOR, 16'h0, 16'h0);
    bus.rsp_ready = 1'b1;
    wait_rsp(target);
    n_checks++;
    if (busy !== 1'b0 || op_count !== exp_count) begin
      n_fail++;
      $display("FAIL stall_release: got busy=%0d cnt=%h, required 0/%h", busy, op_count, exp_count);
    end
  endtask

  task automatic test_zero_wrap();
    int hs;
    int target;
    bus.rsp_ready = 1'b0;
    target = n_pops + 1;
    issue(0, OP_AND, 16'h00FF, 16'hFF00, hs);
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_flag: got valid=%0d zero=%0d, required 1/1", bus.rsp_valid, bus.rsp_zero);
    end
    bus.rsp_ready = 1'b1;
    wait_rsp(target);
    force u_dut.op_count_reg = 16'hFFFE;
    tick();
    release u_dut.op_count_reg;
    #1;
    n_checks++;
    if (op_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL preload: got %h, required fffe", op_count);
    end
    target = n_pops + 1;
    issue(1, OP_OR, 16'h0F00, 16'h00F0, hs);
    wait_rsp(target);
    n_checks++;
    if (op_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL count_ffff: got %h, required ffff", op_count);
    end
    target = n_pops + 1;
    issue(0, OP_NOT, 16'h0F0F, 16'h0000, hs);
    wait_rsp(target);
    n_checks++;
    if (op_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: got %h, required 0000", op_count);
    end
  endtask

  task automatic test_reset_midop();
    int hs;
    int pops_before;
    exp_t e;
    bus.rsp_ready = 1'b1;
    issue(1, OP_NOR, 16'h1200, 16'h0034, hs);
    tick();
    n_checks++;
    if (busy !== 1'b1 || bus.bw_funct !== FN_NOT) begin
      n_fail++;
      $display("FAIL midop_exec2: got busy=%0d f=%b, required 1/11", busy, bus.bw_funct);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || op_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL midop_reset: got busy=%0d valid=%0d cnt=%h, required 0/0/0000",
               busy, bus.rsp_valid, op_count);
    end
    rst = 1'b0;
    sb.delete();
    exp_count = 16'h0000;
    pops_before = n_pops;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (n_pops != pops_before) begin
      n_fail++;
      $display("FAIL midop_discard: got %0d responses, required 0", n_pops - pops_before);
    end
    drive_port(0, 1'b1, OP_XOR, 16'hAAAA, 16'h0F0F);
    drive_port(1, 1'b1, OP_XOR, 16'h5555, 16'h0F0F);
    #1;
    n_checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_tie: got ready=%b, required 01", {bus.req1_ready, bus.req0_ready});
    end
    e.id = 1'b0;
    e.data = ref_op(OP_XOR, 16'hAAAA, 16'h0F0F);
    sb.push_back(e);
    $display("req  port=0 op=2 a=aaaa b=0f0f cycle=%0d", cyc);
    tick();
    drive_port(0, 1'b0, OP_XOR, 16'h0, 16'h0);
    drive_port(1, 1'b0, OP_XOR, 16'h0, 16'h0);
    wait_rsp(pops_before + 1);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    bus.rsp_ready = 1'b1;
    fp_bus.req0_valid = 1'b0; fp_bus.req0_op = OP_AND; fp_bus.req0_a = 16'h00F0;
    fp_bus.req0_b = 16'h0FF0;
    fp_bus.req1_valid = 1'b0; fp_bus.req1_op = OP_OR; fp_bus.req1_a = 16'h1234;
    fp_bus.req1_b = 16'h4321;
    fp_bus.rsp_ready = 1'b1;
    test_reset();
    test_xor();
    test_compound();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_zero_wrap();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
